// File: rtl/lfsr_stream_if.sv
// Output stream bundle for lfsr_stream.
// master drives data/valid, slave drives ready.
interface lfsr_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR pattern source with a valid/ready output stream.
// Define LFSR_LOCKUP_EN to enable all-zero state recovery.
module lfsr_stream #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] TAPS    = 8'hB8,
    parameter int               COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   seed,
    input  logic               seed_load,
    input  logic               start,
    input  logic               mode,
    input  logic [COUNT_W-1:0] length,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               lockup,
    lfsr_stream_if.master      stream
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] len_q, len_d;
    logic [COUNT_W-1:0] cnt_inc;
    logic               mode_q, mode_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               lock_q, lock_d;
    logic               hs;
    logic               zero;
    logic               zero_d;
    logic [WIDTH-1:0]   stepped;

    assign hs      = valid_q & stream.out_ready;
    assign cnt_inc = cnt_q + COUNT_W'(1);
    assign stepped = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

`ifdef LFSR_LOCKUP_EN
    assign zero   = (lfsr_q == '0);
    assign zero_d = (lfsr_d == '0);
`else
    assign zero   = 1'b0;
    assign zero_d = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: zero-length bursts spend one cycle in RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (!mode_q && len_q == '0)
                    state_d = DONE;
                else if (stop)
                    state_d = DONE;
                else if (hs && !mode_q && cnt_inc == len_q)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: seed load, run setup, stepping
    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        len_d  = len_q;
        unique case (state_q)
            IDLE: begin
                if (seed_load) lfsr_d = seed;
                if (start) begin
                    mode_d = mode;
                    len_d  = length;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                if (zero) begin
                    lfsr_d = WIDTH'(1);
                end else if (hs) begin
                    lfsr_d = stepped;
                    if (cnt_q != '1) cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    // Output next values, predicted from next state so they register cleanly
    always_comb begin
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
        lock_d  = (state_d == RUN) && zero_d;
        valid_d = (state_d == RUN)
                  && !(!mode_d && len_d == '0)
                  && !zero_d;
    end

    // Datapath registers; reset restarts the sequence from the seed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= seed;
            cnt_q  <= '0;
            len_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            mode_q <= mode_d;
        end
    end

    // Registered status and stream outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lock_q  <= lock_d;
        end
    end

    assign stream.out_data  = lfsr_q;
    assign stream.out_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign lockup           = lock_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Self-checking bench for lfsr_stream (WIDTH=8, TAPS=8'hB8).
// Reference model steps the sequence arithmetically per handshake.
module tb_lfsr_stream;

`ifdef LFSR_LOCKUP_EN
    localparam bit LK_EN = 1'b1;
`else
    localparam bit LK_EN = 1'b0;
`endif
    localparam int TAPS_I = 'hB8;

    logic       clk;
    logic       rst_n;
    logic [7:0] seed;
    logic       seed_load;
    logic       start;
    logic       mode;
    logic [7:0] length;
    logic       stop;
    logic       busy;
    logic       done;
    logic       lockup;

    lfsr_stream_if #(.WIDTH(8)) bus ();

    lfsr_stream #(
        .WIDTH  (8),
        .TAPS   (8'hB8),
        .COUNT_W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed     (seed),
        .seed_load(seed_load),
        .start    (start),
        .mode     (mode),
        .length   (length),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .lockup   (lockup),
        .stream   (bus.master)
    );

    int         n_checks;
    int         n_fail;
    logic [7:0] mstate;
    logic [7:0] got[$];
    int         lk_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        int fb;
        int v;
        fb = 0;
        v  = int'(s);
        for (int i = 0; i < 8; i++)
            if (((v >> i) & 1) == 1 && ((TAPS_I >> i) & 1) == 1)
                fb++;
        return 8'(((v * 2) % 256) + (fb % 2));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] val);
        seed  = val;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        mstate = val;
    endtask

    task automatic check_word(input string name, input int idx,
                              input logic [7:0] exp);
        n_checks++;
        if (got.size() <= idx) begin
            n_fail++;
            $display("FAIL %s word%0d: missing, required %02h",
                     name, idx, exp);
        end else if (got[idx] !== exp) begin
            n_fail++;
            $display("FAIL %s word%0d: got %02h required %02h",
                     name, idx, got[idx], exp);
        end
    endtask

    task automatic do_run(input bit m, input int len, input bit ld,
                          input logic [7:0] ld_val, input int ready_pct,
                          input int stop_after, input int stall_at,
                          input int stall_n, input string name);
        int words  = 0;
        int stalls = 0;
        int cyc    = 0;
        bit fin    = 0;
        bit hs;
        bit lk_exp;
        got.delete();
        lk_seen   = 0;
        start     = 1'b1;
        mode      = m;
        length    = 8'(len);
        seed_load = ld;
        if (ld) begin
            seed   = ld_val;
            mstate = ld_val;
        end
        step();
        start     = 1'b0;
        seed_load = 1'b0;
        while (!fin) begin
            if (cyc > 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s timeout: words %0d", name, words);
                break;
            end
            cyc++;
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s run_status: busy %b done %b required 1 0",
                         name, busy, done);
            end
            lk_exp = LK_EN && (mstate == 8'h00);
            n_checks++;
            if (lockup !== lk_exp) begin
                n_fail++;
                $display("FAIL %s lockup: got %b required %b",
                         name, lockup, lk_exp);
            end
            if (lockup === 1'b1) lk_seen++;
            if (lk_exp || (!m && len == 0)) begin
                if (lk_exp) mstate = 8'h01;
                if (!m && len == 0) fin = 1;
                n_checks++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s idle_valid: got %b required 0",
                             name, bus.out_valid);
                end
            end else begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== mstate) begin
                    n_fail++;
                    $display("FAIL %s word: valid %b data %02h required 1 %02h",
                             name, bus.out_valid, bus.out_data, mstate);
                end
                hs = ($urandom_range(99) < ready_pct);
                if (stall_at == words && stalls < stall_n) begin
                    hs = 0;
                    stalls++;
                end
                if (hs && stop_after > 0 && words == stop_after - 1)
                    stop = 1'b1;
                bus.out_ready = hs;
                if (hs) begin
                    got.push_back(mstate);
                    mstate = lfsr_next(mstate);
                    words++;
                    if ((!m && words == len) || stop) fin = 1;
                end
            end
            step();
            stop          = 1'b0;
            bus.out_ready = 1'b0;
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b1 || lockup !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: valid %b busy %b done %b lk %b required 0 0 1 0",
                     name, bus.out_valid, busy, done, lockup);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: done %b busy %b required 0 0",
                     name, done, busy);
        end
    endtask

    task automatic test_reset();
        seed  = 8'h01;
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || lockup !== 1'b0 ||
            bus.out_data !== 8'h01) begin
            n_fail++;
            $display("FAIL reset: valid %b busy %b done %b lk %b data %02h required 0 0 0 0 01",
                     bus.out_valid, busy, done, lockup, bus.out_data);
        end
        rst_n = 1'b1;
        step();
        mstate = 8'h01;
    endtask

    task automatic test_burst();
        do_run(0, 5, 0, 8'h00, 100, -1, -1, 0, "burst");
        check_word("burst", 0, 8'h01);
        check_word("burst", 1, 8'h02);
        check_word("burst", 2, 8'h04);
        check_word("burst", 3, 8'h08);
        check_word("burst", 4, 8'h11);
    endtask

    task automatic test_backpressure();
        do_reset(8'h01);
        do_run(0, 5, 0, 8'h00, 100, -1, 1, 3, "backpressure");
        check_word("backpressure", 0, 8'h01);
        check_word("backpressure", 1, 8'h02);
        check_word("backpressure", 2, 8'h04);
        check_word("backpressure", 4, 8'h11);
    endtask

    task automatic test_free_run_stop();
        do_reset(8'h01);
        do_run(1, 0, 0, 8'h00, 100, 4, -1, 0, "free_run");
        n_checks++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL free_run count: got %0d required 4", got.size());
        end
        do_run(0, 1, 0, 8'h00, 100, -1, -1, 0, "continue");
        check_word("continue", 0, 8'h11);
    endtask

    task automatic test_seed_priority();
        do_run(0, 2, 1, 8'hA5, 100, -1, -1, 0, "seed_priority");
        check_word("seed_priority", 0, 8'hA5);
    endtask

    task automatic test_zero_length();
        do_run(0, 0, 0, 8'h00, 100, -1, -1, 0, "zero_length");
        n_checks++;
        if (got.size() != 0) begin
            n_fail++;
            $display("FAIL zero_length count: got %0d required 0", got.size());
        end
    endtask

    task automatic test_stop_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: busy %b done %b valid %b required 0 0 0",
                     busy, done, bus.out_valid);
        end
    endtask

    task automatic test_lockup();
        do_reset(8'h00);
        do_run(0, 3, 0, 8'h00, 100, -1, -1, 0, "lockup");
        check_word("lockup", 0, LK_EN ? 8'h01 : 8'h00);
        check_word("lockup", 1, LK_EN ? 8'h02 : 8'h00);
        check_word("lockup", 2, LK_EN ? 8'h04 : 8'h00);
        n_checks++;
        if (lk_seen != (LK_EN ? 1 : 0)) begin
            n_fail++;
            $display("FAIL lockup pulses: got %0d required %0d",
                     lk_seen, LK_EN ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset(8'h01);
        start = 1'b1;
        mode  = 1'b1;
        step();
        start         = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        bus.out_ready = 1'b0;
        seed          = 8'h3C;
        rst_n         = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || bus.out_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL mid_reset: valid %b busy %b done %b data %02h required 0 0 0 3c",
                     bus.out_valid, busy, done, bus.out_data);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_after: done %b busy %b required 0 0",
                     done, busy);
        end
        mstate = 8'h3C;
        do_run(0, 3, 0, 8'h00, 100, -1, -1, 0, "after_reset");
        check_word("after_reset", 0, 8'h3C);
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            bit         m;
            bit         ld;
            int         len;
            int         pct;
            int         sa;
            logic [7:0] sv;
            m   = 1'($urandom_range(1));
            ld  = 1'($urandom_range(1));
            len = int'($urandom_range(12));
            pct = int'($urandom_range(100, 30));
            sv  = 8'($urandom_range(255));
            sa  = m ? int'($urandom_range(10, 1))
                    : ($urandom_range(3) == 0 ? int'($urandom_range(8, 1)) : -1);
            do_run(m, len, ld, sv, pct, sa, -1, 0, "random");
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        seed          = 8'h00;
        seed_load     = 1'b0;
        start         = 1'b0;
        mode          = 1'b0;
        length        = 8'h00;
        stop          = 1'b0;
        bus.out_ready = 1'b0;
        mstate        = 8'h00;
        lk_seen       = 0;
        test_reset();
        test_burst();
        test_backpressure();
        test_free_run_stop();
        test_seed_priority();
        test_zero_length();
        test_stop_idle();
        test_lockup();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised Fibonacci LFSR pattern generator with a valid/ready output stream, run-time seed loading, burst-length and free-run modes, and an explicit completion pulse. It is the next-generation pseudo-random source for the design's test-pattern and scrambler paths. It replaces fixed-width, free-running generators with a block that downstream consumers can backpressure.

## Interface

Parameters:
- WIDTH, 8, LFSR state and output width; legal range 2..32.
- TAPS, 8'hB8, WIDTH-bit feedback mask; bit i set means state[i] feeds the XOR.
- COUNT_W, 8, width of the burst length and word counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- seed  in  WIDTH  seed value, sampled on reset and on seed_load.
- seed_load  in  1  load seed into the state; honoured only in IDLE.
- start  in  1  begin a run; honoured only in IDLE.
- mode  in  1  0 = burst of `length` words, 1 = free-run until stop; sampled with start.
- length  in  COUNT_W  burst word count; sampled with start.
- stop  in  1  end the current run after any handshake in the same cycle.
- out_data  out  WIDTH  current LFSR state.
- out_valid  out  1  out_data is offered.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run ends normally or via stop.
- lockup  out  1  one-cycle pulse on all-zero recovery (see Configuration).

## Operation

- States: IDLE, RUN, DONE.
- Step function: next = {state[WIDTH-2:0], ^(state & TAPS)}.
- IDLE:
  - seed_load loads state <= seed.
  - start latches mode and length, clears the counter and moves to RUN.
  - If seed_load and start arrive together, the load is applied and the first word emitted is the new seed.
- RUN:
  - out_valid = 1 and out_data = state.
  - A handshake (out_valid & out_ready) steps the state and increments the counter.
  - Without a handshake, state and out_data hold.
  - Burst mode: after the handshake that makes the counter equal to length, go to DONE.
  - length = 0: RUN lasts one cycle with out_valid = 0, no words are emitted, then DONE.
  - Free-run: the counter saturates at all-ones and does not wrap; only stop ends the run.
  - stop in either mode goes to DONE. A handshake in the same cycle completes and steps the state.
- DONE: done = 1 for one cycle, then IDLE. The state is retained, so the next run continues the sequence.
- start, seed_load and stop are ignored outside their stated states; stop in IDLE has no effect.
- Reset values:
  - state = seed port value.
  - FSM = IDLE and counter = 0.
  - out_valid = busy = done = lockup = 0.
  - out_data = seed.
- Reset mid-run aborts the run immediately; done is not pulsed.

## Timing

- start at cycle N: busy and out_valid are high from N+1, and out_data = seed or the retained state.
- One word per cycle is possible while out_ready is held high.
- The stepped state appears on out_data the cycle after a handshake.
- Final handshake at cycle M: out_valid and busy are low at M+1, done is high at M+1 only, and IDLE is reached at M+2.
- A start at M+2 is accepted.
- out_data and out_valid are registered; out_valid never depends combinationally on out_ready.

## Configuration

- LFSR_LOCKUP_EN defined:
  - An all-zero state in RUN is replaced by WIDTH'd1 in that cycle, with out_valid forced low for that cycle.
  - lockup pulses for one cycle; a zero word is never emitted.
- LFSR_LOCKUP_EN undefined:
  - There is no detection and lockup is tied to 0.
  - An all-zero seed emits zero words for the whole run.

## Test plan

- Burst sequence:
  - Stimulus: WIDTH=8, TAPS=8'hB8, reset with seed=8'h01; start with mode=0, length=5; out_ready=1.
  - Response: words 01,02,04,08,11 on consecutive cycles; done pulses the cycle after 11; busy drops.
- Backpressure:
  - Stimulus: same run with out_ready=0 for 3 cycles after the second word is offered.
  - Response: out_data holds 02 with out_valid=1 during the stall; the sequence continues 04,08,11 unchanged.
- Free-run, stop and continuation:
  - Stimulus: free-run start; stop asserted together with the handshake of the 4th word.
  - Response: 4 words delivered; done pulses; the next start emits 11 first (retained state).
- Seed priority and zero length:
  - Stimulus 1: seed_load with seed=8'hA5 and start in the same IDLE cycle.
    - Response: first word A5.
  - Stimulus 2: start with length=0.
    - Response: no out_valid; done pulses 2 cycles after start.
- Lockup:
  - Stimulus: seed=0, then start with length=3.
  - Response with LFSR_LOCKUP_EN defined: lockup pulses once; words 01,02,04.
  - Response without LFSR_LOCKUP_EN: words 00,00,00; lockup stays 0.
- Reset mid-run:
  - Stimulus: rst_n low during RUN.
  - Response: next cycle out_valid=0, busy=0, done=0, out_data=seed; a new start works normally.
